// File: rtl/he_accel_pkg.sv
// Shared types and constants for the HE accelerator sequencer.
// Line counts assume 512 x 64-bit coefficients packed 4 per 256-bit line.
package he_accel_pkg;
    localparam int N_COEFF           = 512;
    localparam int COEFF_W           = 64;
    localparam int LINE_W            = 256;
    localparam int ADDR_W            = 32;
    localparam int LINES_PER_POLY    = 128;
    localparam int LOAD_LINES        = 512;
    localparam int STORE_LINES_MUL   = 384;
    localparam int STORE_LINES_RELIN = 256;

    typedef enum logic [1:0] {
        OP_MUL      = 2'b00,
        OP_MULRELIN = 2'b01
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_COMPUTE, S_STORE, S_DONE
    } state_e;

    localparam logic [2:0] SEL_CT0_0  = 3'd0;
    localparam logic [2:0] SEL_CT0_1  = 3'd1;
    localparam logic [2:0] SEL_CT1_0  = 3'd2;
    localparam logic [2:0] SEL_CT1_1  = 3'd3;
    localparam logic [2:0] SEL_C0_OUT = 3'd4;
    localparam logic [2:0] SEL_C1_OUT = 3'd5;
    localparam logic [2:0] SEL_C2_OUT = 3'd6;

    function automatic logic op_legal(logic [1:0] op);
        return (op == OP_MUL) || (op == OP_MULRELIN);
    endfunction
endpackage

// File: rtl/he_line_agu.sv
// Line counter and base+offset line address generator shared by LOAD and STORE.
module he_line_agu
    import he_accel_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [8:0]        last_idx_i,
    output logic [8:0]        cnt_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [8:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 9'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Wraps modulo 2^ADDR_W by design.
    assign addr_o = base_i + {{(ADDR_W-14){1'b0}}, cnt_q, 5'b0};
    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == last_idx_i);
endmodule

// File: rtl/he_accel_ctrl.sv
// Command sequencer: load two ciphertexts, run the multiply, store the result, report tag.
module he_accel_ctrl
    import he_accel_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_src_addr_i,
    input  logic [ADDR_W-1:0] cmd_dst_addr_i,
    input  logic [2:0]        cmd_tag_i,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_resp_i,
    output logic              buf_we_o,
    output logic [2:0]        buf_sel_o,
    output logic [6:0]        buf_index_o,
    output logic [LINE_W-1:0] buf_wdata_o,
    input  logic [LINE_W-1:0] buf_rdata_i,
    output logic              core_start_o,
    output logic              core_relin_o,
    input  logic              core_done_i,
    output logic              done_valid_o,
    output logic [2:0]        done_tag_o,
    output logic              done_err_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [2:0]        tag_q;
    logic              relin_q, err_q;

    logic              accept, agu_clr, agu_inc, agu_last;
    logic [ADDR_W-1:0] agu_base, agu_addr;
    logic [8:0]        agu_last_idx, line_cnt;

    he_line_agu u_agu (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (agu_clr),
        .inc_i      (agu_inc),
        .base_i     (agu_base),
        .last_idx_i (agu_last_idx),
        .cnt_o      (line_cnt),
        .addr_o     (agu_addr),
        .last_o     (agu_last)
    );

    // Every output is forced low while rst_i is high, not just after the edge.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        agu_clr       = 1'b0;
        agu_inc       = 1'b0;
        agu_base      = src_q;
        agu_last_idx  = 9'(LOAD_LINES - 1);
        cmd_ready_o   = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_address_o = '0;
        mem_wdata_o   = '0;
        buf_we_o      = 1'b0;
        buf_sel_o     = '0;
        buf_index_o   = '0;
        buf_wdata_o   = '0;
        core_start_o  = 1'b0;
        core_relin_o  = 1'b0;
        done_valid_o  = 1'b0;
        done_tag_o    = '0;
        done_err_o    = 1'b0;
        if (!rst_i) begin
            buf_wdata_o = mem_rdata_i;
            mem_wdata_o = buf_rdata_i;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        accept  = 1'b1;
                        agu_clr = 1'b1;
                        state_d = op_legal(cmd_op_i) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: begin
                    mem_read_o    = 1'b1;
                    mem_address_o = agu_addr;
                    buf_sel_o     = {1'b0, line_cnt[8:7]};
                    buf_index_o   = line_cnt[6:0];
                    if (mem_resp_i) begin
                        buf_we_o = 1'b1;
                        agu_inc  = 1'b1;
                        if (agu_last) state_d = S_START;
                    end
                end
                S_START: begin
                    core_start_o = 1'b1;
                    core_relin_o = relin_q;
                    state_d      = S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (core_done_i) begin
                        agu_clr = 1'b1;
                        state_d = S_STORE;
                    end
                end
                S_STORE: begin
                    agu_base      = dst_q;
                    agu_last_idx  = relin_q ? 9'(STORE_LINES_RELIN - 1) : 9'(STORE_LINES_MUL - 1);
                    mem_write_o   = 1'b1;
                    mem_address_o = agu_addr;
                    buf_sel_o     = SEL_C0_OUT + {1'b0, line_cnt[8:7]};
                    buf_index_o   = line_cnt[6:0];
                    if (mem_resp_i) begin
                        agu_inc = 1'b1;
                        if (agu_last) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done_valid_o = 1'b1;
                    done_tag_o   = tag_q;
                    done_err_o   = err_q;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            tag_q   <= '0;
            relin_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q   <= cmd_src_addr_i & ~ADDR_W'(32'h1f);
                dst_q   <= cmd_dst_addr_i & ~ADDR_W'(32'h1f);
                tag_q   <= cmd_tag_i;
                relin_q <= (cmd_op_i == OP_MULRELIN);
                err_q   <= !op_legal(cmd_op_i);
            end
        end
    end
endmodule

// File: tb/tb_he_accel_ctrl.sv
// Directed bench for he_accel_ctrl with a behavioural line memory and operand buffer.
module tb_he_accel_ctrl;
    logic         clk = 0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [31:0]  cmd_src, cmd_dst;
    logic [2:0]   cmd_tag;
    logic         mem_read, mem_write, mem_resp;
    logic [31:0]  mem_address;
    logic [255:0] mem_rdata, mem_wdata, buf_wdata, buf_rdata;
    logic         buf_we;
    logic [2:0]   buf_sel;
    logic [6:0]   buf_index;
    logic         core_start, core_relin, core_done;
    logic         done_valid, done_err;
    logic [2:0]   done_tag;

    he_accel_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_src_addr_i(cmd_src), .cmd_dst_addr_i(cmd_dst), .cmd_tag_i(cmd_tag),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
        .mem_rdata_i(mem_rdata), .mem_wdata_o(mem_wdata), .mem_resp_i(mem_resp),
        .buf_we_o(buf_we), .buf_sel_o(buf_sel), .buf_index_o(buf_index),
        .buf_wdata_o(buf_wdata), .buf_rdata_i(buf_rdata),
        .core_start_o(core_start), .core_relin_o(core_relin), .core_done_i(core_done),
        .done_valid_o(done_valid), .done_tag_o(done_tag), .done_err_o(done_err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] bpat(logic [2:0] s, logic [6:0] i);
        return {8{22'h2A5A5A, s, i}};
    endfunction
    assign buf_rdata = bpat(buf_sel, buf_index);

    int passed = 0, total = 0;
    int cyc, core_lat, rand_lat, lat, wcnt;
    int spur_done_cyc, spur_resp_cyc, spur_cmd_cyc;
    int ld_cnt, ld_err, st_cnt, st_err, st_first_cyc, both, stab, acc_err, req_cyc;
    int start_cnt, start_cyc, done_at, dv_cnt, dv_cyc;
    logic [31:0] exp_src, exp_dst, first_rd, last_ld, last_st;
    logic [2:0]  dv_tag;
    logic        dv_err, relin_seen, seen_rd, pend;
    logic [33:0] pend_sig;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctl"}, {cmd_ready, mem_read, mem_write, mem_address, buf_we, buf_sel, buf_index,
                            core_start, core_relin, done_valid, done_tag, done_err}, 0);
        chk({tag, "_data"}, buf_wdata | mem_wdata, 0);
    endtask

    task automatic clr_stats();
        ld_cnt = 0; ld_err = 0; st_cnt = 0; st_err = 0; st_first_cyc = -1; both = 0; stab = 0;
        acc_err = 0; req_cyc = 0; start_cnt = 0; start_cyc = -1; done_at = 0; dv_cnt = 0;
        dv_cyc = -1; dv_tag = 0; dv_err = 0; relin_seen = 0; seen_rd = 0; pend = 0; pend_sig = 0;
        first_rd = 0; last_ld = 0; last_st = 0; wcnt = 0; lat = 0;
        spur_done_cyc = -1; spur_resp_cyc = -1; spur_cmd_cyc = -1;
    endtask

    // One cycle: drive inputs at negedge, then sample and score 1 time unit later.
    task automatic step();
        @(negedge clk);
        cyc++;
        cmd_valid = (cyc == spur_cmd_cyc);
        core_done = (done_at != 0 && cyc == done_at) || (cyc == spur_done_cyc);
        mem_resp  = 0;
        mem_rdata = {8{mem_address}};
        if (rst) wcnt = 0;
        else if (mem_read || mem_write) begin
            if (wcnt >= lat) begin
                mem_resp = 1; wcnt = 0;
                lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
            end else wcnt++;
        end
        if (cyc == spur_resp_cyc) mem_resp = 1;
        #1;
        if (mem_read && mem_write) both++;
        if (mem_read || mem_write) req_cyc++;
        if (mem_read && !seen_rd) begin first_rd = mem_address; seen_rd = 1; end
        if (pend && {mem_read, mem_write, mem_address} !== pend_sig) stab++;
        pend     = (mem_read || mem_write) && !mem_resp;
        pend_sig = {mem_read, mem_write, mem_address};
        if (cmd_valid && cmd_ready) acc_err++;
        if (buf_we) begin
            if (!mem_resp || !mem_read || mem_address !== exp_src + 32'(ld_cnt) * 32
                || buf_sel !== 3'(ld_cnt / 128) || buf_index !== 7'(ld_cnt % 128)
                || buf_wdata !== {8{mem_address}}) ld_err++;
            last_ld = mem_address;
            ld_cnt++;
        end
        if (mem_write && mem_resp) begin
            if (st_cnt == 0) st_first_cyc = cyc;
            if (mem_address !== exp_dst + 32'(st_cnt) * 32 || buf_sel !== 3'(4 + st_cnt / 128)
                || buf_index !== 7'(st_cnt % 128)
                || mem_wdata !== bpat(3'(4 + st_cnt / 128), 7'(st_cnt % 128))) st_err++;
            last_st = mem_address;
            st_cnt++;
        end
        if (core_start) begin
            start_cnt++; start_cyc = cyc; relin_seen = core_relin;
            if (done_at == 0) done_at = cyc + core_lat;
        end
        if (done_valid) begin dv_cnt++; dv_cyc = cyc; dv_tag = done_tag; dv_err = done_err; end
    endtask

    // Offers a command so that it is accepted at "edge 0"; cycle 1 follows.
    task automatic issue(logic [1:0] op, logic [31:0] src, logic [31:0] dst, logic [2:0] tag);
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_tag = tag;
        #1 chk("ready_before_issue", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 0; cmd_op = 2'b01; cmd_tag = 3'd7; cyc = 0;
    endtask

    task automatic run(int budget);
        int n = 0;
        while (dv_cnt == 0 && n < budget) begin step(); n++; end
        chk("done_timeout", dv_cnt != 0, 1);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_src = 0; cmd_dst = 0; cmd_tag = 0;
        mem_resp = 0; mem_rdata = 0; core_done = 0; cyc = 0; core_lat = 10; rand_lat = 0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 0;
        #1 chk("ready_after_reset", cmd_ready, 1);

        // MUL, zero-wait memory, with spurious core_done/mem_resp/cmd_valid injected
        clr_stats();
        exp_src = 32'h1000; exp_dst = 32'h8000;
        issue(2'b00, 32'h1000, 32'h8000, 3'd5);
        spur_done_cyc = 100; spur_resp_cyc = 516; spur_cmd_cyc = 517;
        run(3000);
        chk("mul_ld_cnt", ld_cnt, 512);
        chk("mul_ld_err", ld_err, 0);
        chk("mul_first_rd", first_rd, 32'h1000);
        chk("mul_last_ld", last_ld, 32'h4FE0);
        chk("mul_start_cnt", start_cnt, 1);
        chk("mul_start_cyc", start_cyc, 513);
        chk("mul_relin", relin_seen, 0);
        chk("mul_st_cnt", st_cnt, 384);
        chk("mul_st_err", st_err, 0);
        chk("mul_st_first_cyc", st_first_cyc, 523 + 1);
        chk("mul_last_st", last_st, 32'hAFE0);
        chk("mul_dv_cyc", dv_cyc, 523 + 385);
        chk("mul_dv_tag", dv_tag, 5);
        chk("mul_dv_err", dv_err, 0);
        chk("mul_acc_err", acc_err, 0);
        chk("mul_rw_both", both, 0);
        step();
        chk("mul_idle_ready", cmd_ready, 1);
        chk("mul_dv_once", dv_cnt, 1);

        // MULRELIN, 0-3 cycle latency, misaligned source base
        clr_stats(); rand_lat = 1;
        exp_src = 32'h1000; exp_dst = 32'h2000_0000;
        issue(2'b01, 32'h1013, 32'h2000_0000, 3'd6);
        run(8000);
        chk("rl_first_rd", first_rd, 32'h1000);
        chk("rl_ld_cnt", ld_cnt, 512);
        chk("rl_ld_err", ld_err, 0);
        chk("rl_relin", relin_seen, 1);
        chk("rl_st_cnt", st_cnt, 256);
        chk("rl_st_err", st_err, 0);
        chk("rl_last_st", last_st, 32'h2000_1FE0);
        chk("rl_dv_tag", dv_tag, 6);
        chk("rl_dv_err", dv_err, 0);
        chk("rl_stable", stab, 0);
        chk("rl_rw_both", both, 0);
        repeat (3) step();
        chk("rl_dv_once", dv_cnt, 1);
        rand_lat = 0;

        // Illegal op
        clr_stats();
        issue(2'b11, 32'h3000, 32'h4000, 3'd3);
        step();
        chk("ill_dv_c1", {done_valid, done_err, done_tag}, {1'b1, 1'b1, 3'd3});
        step();
        chk("ill_ready_c2", cmd_ready, 1);
        chk("ill_no_traffic", req_cyc, 0);

        // Reset mid-LOAD, then a fresh command
        clr_stats();
        exp_src = 32'h1000; exp_dst = 32'h8000;
        issue(2'b00, 32'h1000, 32'h8000, 3'd2);
        begin
            int n = 0;
            while (ld_cnt < 201 && n < 1000) begin step(); n++; end
        end
        chk("rst_reached_line200", ld_cnt, 201);
        rst = 1;
        #1 chk_zero("rst_during");
        @(posedge clk);
        #1 chk_zero("rst_after_edge");
        step();
        @(negedge clk) rst = 0;
        repeat (5) step();
        chk("rst_no_done", dv_cnt, 0);
        chk("rst_idle_ready", cmd_ready, 1);
        clr_stats();
        issue(2'b00, 32'h1000, 32'h8000, 3'd4);
        run(3000);
        chk("rst_fresh_first_rd", first_rd, 32'h1000);
        chk("rst_fresh_ld", {ld_cnt, ld_err}, {32'd512, 32'd0});
        chk("rst_fresh_st", {st_cnt, st_err}, {32'd384, 32'd0});
        chk("rst_fresh_tag", {dv_tag, dv_err}, {3'd4, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/he_accel_ctrl.md
# he_accel_ctrl

Sequencer for the homomorphic-encryption accelerator behind the Tomasulo accelerator reservation station. It accepts one command at a time (op, source/destination base address, ROB tag) and burst-loads the two input ciphertexts from memory into the accelerator operand buffers over the 256-bit line port. It then starts the multiply (optionally with relinearization), writes the result polynomials back to memory line by line, and broadcasts completion with the ROB tag. Relinearization keys are preloaded and are outside this block's scope.

## Interface
- N_COEFF, 512, coefficients per polynomial
- COEFF_W, 64, coefficient width in bits
- LINE_W, 256, memory line width; 4 coefficients per line
- ADDR_W, 32, byte address width

- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and when rst is low
- cmd_op  in  2  00 MUL, 01 MULRELIN, 1x illegal
- cmd_src_addr / cmd_dst_addr  in  ADDR_W  byte bases; bits [4:0] ignored (treated as 0)
- cmd_tag  in  3  ROB tag
- mem_read / mem_write  out  1  line request, held until mem_resp
- mem_address  out  ADDR_W  line-aligned address
- mem_rdata  in  LINE_W  read data, valid with mem_resp
- mem_wdata  out  LINE_W  equal to buf_rdata
- mem_resp  in  1  one-cycle completion
- buf_we  out  1  operand-buffer line write
- buf_sel  out  3  0 ct0[0], 1 ct0[1], 2 ct1[0], 3 ct1[1], 4 c0_out, 5 c1_out, 6 c2_out
- buf_index  out  7  line within polynomial (0..127)
- buf_wdata  out  LINE_W  equal to mem_rdata
- buf_rdata  in  LINE_W  combinational read of buf_sel/buf_index
- core_start  out  1  one-cycle pulse; core_relin  out  1  level, valid during core_start
- core_done  in  1  one-cycle pulse from datapath
- done_valid  out  1  one-cycle completion pulse; done_tag  out  3; done_err  out  1

## Operation
- States:
  - IDLE: on cmd_valid && cmd_ready, latch op/addrs/tag and clear line_cnt. Go to LOAD, or to DONE with err if op is illegal.
  - LOAD: mem_read=1, mem_address = src + line_cnt*32. On mem_resp: buf_we=1 in the same cycle, buf_sel = line_cnt[8:7], buf_index = line_cnt[6:0], line_cnt++. After the resp for line 511, go to START.
  - START: core_start=1 for one cycle, core_relin = (op==MULRELIN). Go to COMPUTE.
  - COMPUTE: wait for core_done, then clear line_cnt and go to STORE.
  - STORE: mem_write=1, mem_address = dst + line_cnt*32, buf_sel = 4 + line_cnt[8:7], buf_index = line_cnt[6:0]. On mem_resp, line_cnt++. The last line is 383 for MUL (3 polys) and 255 for MULRELIN (2 polys); after it, go to DONE.
  - DONE: done_valid=1 with done_tag; done_err=1 only for an illegal op. Go to IDLE.
- mem_read and mem_write are never asserted together. The address advances the cycle after mem_resp, and the request stays asserted across consecutive lines (no bubble).
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- core_done outside COMPUTE is ignored. mem_resp outside LOAD/STORE is ignored. cmd_valid outside IDLE is not accepted.

## Timing
- Reset: state IDLE, line_cnt 0, and every output 0, including cmd_ready while rst is high. An op in flight is abandoned; no done_valid is issued for it.
- Accept at edge 0; LOAD is active from cycle 1.
- With a zero-wait memory (mem_resp in the first cycle of each request):
  - MUL: LOAD cycles 1–512, START 513, COMPUTE from 514.
  - After core_done at cycle D: STORE D+1 through D+384, DONE D+385, IDLE (cmd_ready=1) D+386.
- Illegal op: DONE at cycle 1, IDLE at cycle 2.
- A new command is accepted no earlier than the cycle after DONE.

## Structure
- Shared package he_accel_pkg holds:
  - op enum and state enum
  - LINES_PER_POLY=128, LOAD_LINES=512, STORE_LINES_MUL=384, STORE_LINES_RELIN=256
  - buf_sel encodings
- Optional sub-module he_line_agu: line counter plus base+offset address generator with last-line compare, shared by LOAD and STORE.

## Test plan
- MUL with zero-wait memory, src=0x1000, dst=0x8000, tag=5 -> 512 buf_we pulses at addresses 0x1000..0x4FE0 and buf_sel sequence 0,1,2,3; core_start at cycle 513 with relin=0; 384 writes to 0x8000..0xAFE0; done_valid with tag 5, err 0.
- MULRELIN with random 0–3 cycle memory latency -> core_relin=1, exactly 256 writes (buf_sel 4,5), done_valid once; mem_read/mem_write stay stable while awaiting resp.
- cmd_op=2'b11, tag=3 -> no memory traffic, done_valid at cycle 1 with done_err=1, cmd_ready at cycle 2.
- cmd_src_addr=0x1013 -> first mem_address 0x1000.
- rst asserted mid-LOAD (line 200) -> next cycle all outputs 0; no done_valid; a fresh command afterwards completes normally starting at line 0.
- Spurious core_done during LOAD and mem_resp during COMPUTE -> ignored; line_cnt and state unchanged; a second cmd_valid during COMPUTE is not accepted.
